pool_stream_sequencer: RTL and testbench

- Control and collection side of the 2x2 max-pool datapath.
- Accepts a raster pixel stream (valid/ready) and drives the pooling block's line-buffer controls and its input line.
- Captures pooled results only at stride-2 window positions and returns them through an output FIFO with valid/ready.
- Sits between the activation stream source and the pooled-output writeback.

---
 rtl/pool_seq_pkg.sv | 15 +
 rtl/pool_out_fifo.sv | 48 ++++
 rtl/pool_stream_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_pool_stream_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_seq_pkg.sv
// Shared types and defaults for the 2x2 max-pool stream sequencer.
package pool_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_STREAM,
      ST_DRAIN,
      ST_DONE
   } state_t;

   localparam int POOL_LAT_DEF  = 3;
   localparam int OUT_DEPTH_DEF = 4;

endpackage

// File: rtl/pool_out_fifo.sv
// Synchronous output FIFO for pooled results; DEPTH must be a power of two.
module pool_out_fifo #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [DATA_W-1:0]        i_data,
   input  logic                     i_pop,
   output logic [DATA_W-1:0]        o_head,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_data;
   end

   // Head reads as zero when empty so the output is clean out of reset.
   assign o_empty = (r_count == '0);
   assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/pool_stream_sequencer.sv
// Raster-stream control and stride-2 result collection for the 2x2 max-pool block.
// Optional build macro POOL_SEQ_PERF_EN adds the stall_cycles counter port.
module pool_stream_sequencer
   import pool_seq_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 10,
   parameter int POOL_LAT  = POOL_LAT_DEF,
   parameter int OUT_DEPTH = OUT_DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] row_length,
   input  logic [ADDR_W-1:0] num_rows,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              shifting_line,
   output logic              line_buffer_reset,
   output logic [DATA_W-1:0] input_line,
   output logic              pool_enable,
   input  logic [DATA_W-1:0] pool_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic              busy,
   output logic              done
`ifdef POOL_SEQ_PERF_EN
   ,
   output logic [31:0]       stall_cycles
`endif
);

   localparam int CW = $clog2(OUT_DEPTH);
   localparam int TW = $clog2(POOL_LAT + 2);

   state_t              r_state;
   logic [ADDR_W-1:0]   r_row_len;
   logic [ADDR_W-1:0]   r_num_rows;
   logic [ADDR_W-1:0]   r_row;
   logic [ADDR_W-1:0]   r_col;
   logic                r_shift;
   logic [DATA_W-1:0]   r_input_line;
   logic                r_lbr;
   logic                r_pool_en;
   logic                r_busy;
   logic                r_done;
   logic                r_cap_p0;
   logic [POOL_LAT-1:0] r_tag;

   logic                w_accept;
   logic                w_last_col;
   logic                w_last_row;
   logic                w_tag_exit;
   logic                w_pop;
   logic                w_fifo_empty;
   logic [CW:0]         w_fifo_cnt;
   logic [DATA_W-1:0]   w_fifo_head;
   logic [TW-1:0]       w_tags;

   // Tags still travelling through the pooling block, including the one just issued.
   always_comb begin
      w_tags = TW'(r_cap_p0);
      for (int i = 0; i < POOL_LAT; i++) begin
         w_tags = w_tags + TW'(r_tag[i]);
      end
   end

   // Credit covers every tag in flight, so a tag exit always finds a free slot.
   assign in_ready   = (r_state == ST_STREAM) &&
                       ((int'(w_fifo_cnt) + int'(w_tags)) < OUT_DEPTH);
   assign w_accept   = in_valid && in_ready;
   assign w_last_col = (r_col == (r_row_len - ADDR_W'(1)));
   assign w_last_row = (r_row == (r_num_rows - ADDR_W'(1)));
   assign w_tag_exit = r_tag[POOL_LAT-1];
   assign w_pop      = !w_fifo_empty && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_row_len    <= '0;
         r_num_rows   <= '0;
         r_row        <= '0;
         r_col        <= '0;
         r_shift      <= 1'b0;
         r_input_line <= '0;
         r_lbr        <= 1'b0;
         r_pool_en    <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_cap_p0     <= 1'b0;
         r_tag        <= '0;
      end else begin
         r_shift  <= w_accept;
         if (w_accept) r_input_line <= in_data;
         r_cap_p0 <= w_accept && r_row[0] && r_col[0];
         r_tag    <= (r_tag << 1) | POOL_LAT'(r_cap_p0);
         r_lbr    <= 1'b0;
         r_done   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_row_len  <= row_length;
                  r_num_rows <= num_rows;
                  r_row      <= '0;
                  r_col      <= '0;
                  r_lbr      <= 1'b1;
                  r_busy     <= 1'b1;
                  r_state    <= ST_CLEAR;
               end
            end
            ST_CLEAR: begin
               r_pool_en <= 1'b1;
               if ((r_row_len == '0) || (r_num_rows == '0)) r_state <= ST_DRAIN;
               else                                           r_state <= ST_STREAM;
            end
            ST_STREAM: begin
               if (w_accept) begin
                  if (w_last_col) begin
                     r_col <= '0;
                     r_row <= r_row + ADDR_W'(1);
                     if (w_last_row) r_state <= ST_DRAIN;
                  end else begin
                     r_col <= r_col + ADDR_W'(1);
                  end
               end
            end
            ST_DRAIN: begin
               if ((w_tags == '0) && w_fifo_empty) begin
                  r_pool_en <= 1'b0;
                  r_done    <= 1'b1;
                  r_state   <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_pool_en <= 1'b0;
               r_busy    <= 1'b0;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

   pool_out_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (OUT_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_tag_exit),
      .i_data  (pool_data),
      .i_pop   (w_pop),
      .o_head  (w_fifo_head),
      .o_empty (w_fifo_empty),
      .o_count (w_fifo_cnt)
   );

   assign shifting_line     = r_shift;
   assign input_line        = r_input_line;
   assign line_buffer_reset = r_lbr;
   assign pool_enable       = r_pool_en;
   assign busy              = r_busy;
   assign done              = r_done;
   assign out_valid         = !w_fifo_empty;
   assign out_data          = w_fifo_head;

`ifdef POOL_SEQ_PERF_EN
   logic [31:0] r_stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall <= '0;
      end else if ((r_state == ST_IDLE) && start) begin
         r_stall <= '0;
      end else if ((r_state == ST_STREAM) && in_valid && !in_ready &&
                   (r_stall != 32'hFFFF_FFFF)) begin
         r_stall <= r_stall + 32'd1;
      end
   end

   assign stall_cycles = r_stall;
`endif

endmodule

// File: tb/tb_pool_stream_sequencer.sv
// Self-checking bench for pool_stream_sequencer with a behavioural 2x2 max-pool model.
module tb_pool_stream_sequencer;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 10;
   localparam int LAT    = 3;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [ADDR_W-1:0] row_length;
   logic [ADDR_W-1:0] num_rows;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              shifting_line;
   logic              line_buffer_reset;
   logic [DATA_W-1:0] input_line;
   logic              pool_enable;
   logic [DATA_W-1:0] pool_data;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;
   logic              busy;
   logic              done;
`ifdef POOL_SEQ_PERF_EN
   logic [31:0]       stall_cycles;
`endif

   always #5 clk = ~clk;

   pool_stream_sequencer #(
      .DATA_W (DATA_W), .ADDR_W (ADDR_W), .POOL_LAT (LAT), .OUT_DEPTH (DEPTH)
   ) dut (
      .clk (clk), .rst (rst), .start (start), .row_length (row_length),
      .num_rows (num_rows), .in_valid (in_valid), .in_data (in_data),
      .in_ready (in_ready), .shifting_line (shifting_line),
      .line_buffer_reset (line_buffer_reset), .input_line (input_line),
      .pool_enable (pool_enable), .pool_data (pool_data),
      .out_valid (out_valid), .out_data (out_data), .out_ready (out_ready),
      .busy (busy), .done (done)
`ifdef POOL_SEQ_PERF_EN
      , .stall_cycles (stall_cycles)
`endif
   );

   // Pooling block model: value computed on a shift pulse appears LAT cycles later.
   logic [DATA_W-1:0] pd_in = '0;
   logic [DATA_W-1:0] pd_pipe [LAT];
   always @(posedge clk) begin
      pd_pipe[0] <= pd_in;
      for (int i = 1; i < LAT; i++) pd_pipe[i] <= pd_pipe[i-1];
   end
   assign pool_data = pd_pipe[LAT-1];

   typedef struct {
      int rl;
      int nr;
      bit rv;
      bit rr;
      int exp_outs;
   } vec_t;

   vec_t              tbl [7];
   int                checks = 0;
   int                errors = 0;
   int                cyc = 0;
   logic [DATA_W-1:0] sent  [256];
   logic [DATA_W-1:0] pix_m [256];
   logic [DATA_W-1:0] sb [$];
   logic [DATA_W-1:0] head_q;
   int                acc_cnt, shift_cnt, rl_cur, total_cur;
   int                out_cnt, done_cnt, out_at_done, ir_seen, stalls;
   bit                g_start;

   function automatic logic [DATA_W-1:0] max4(input logic [DATA_W-1:0] a, b, c, d);
      logic [DATA_W-1:0] m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   // One clock: drive at the falling edge, then observe handshakes and outputs.
   task automatic tick(input bit iv, input bit ordy);
      int k;
      @(negedge clk);
      start     = g_start;
      g_start   = 1'b0;
      in_valid  = iv && (acc_cnt < total_cur);
      in_data   = DATA_W'($urandom_range(0, 4095));
      out_ready = ordy;
      #1;
      cyc++;
      pd_in = 16'hF000 | DATA_W'(cyc & 'hFFF);
      if (shifting_line) begin
         k = shift_cnt;
         pix_m[k] = input_line;
         shift_cnt++;
         if (rl_cur > 0 && ((k / rl_cur) % 2 == 1) && ((k % rl_cur) % 2 == 1))
            pd_in = max4(pix_m[k], pix_m[k-1], pix_m[k-rl_cur], pix_m[k-rl_cur-1]);
      end
      if (in_valid && in_ready && rl_cur > 0) begin
         k = acc_cnt;
         sent[k] = in_data;
         acc_cnt++;
         if (((k / rl_cur) % 2 == 1) && ((k % rl_cur) % 2 == 1))
            sb.push_back(max4(sent[k], sent[k-1], sent[k-rl_cur], sent[k-rl_cur-1]));
      end
      if (in_ready) ir_seen++;
      if (in_valid && !in_ready && acc_cnt > 0) stalls++;
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %0h required no output", out_data);
         end else begin
            chk("out_data", 32'(out_data), 32'(sb.pop_front()));
         end
         out_cnt++;
      end
      if (done) begin
         done_cnt++;
         out_at_done = out_cnt;
      end
   endtask

   task automatic begin_frame(input int rl, input int nr);
      row_length  = ADDR_W'(rl);
      num_rows    = ADDR_W'(nr);
      rl_cur      = rl;
      total_cur   = rl * nr;
      acc_cnt     = 0;
      shift_cnt   = 0;
      out_cnt     = 0;
      done_cnt    = 0;
      out_at_done = -1;
      ir_seen     = 0;
      stalls      = 0;
      sb.delete();
      g_start     = 1'b1;
   endtask

   task automatic finish_frame(input int budget, input bit rv, input bit rr,
                               input int exp_outs, input string nm);
      int n;
      n = 0;
      while (done_cnt == 0 && n < budget) begin
         tick(rv ? ($urandom_range(0, 3) != 0) : 1'b1,
              rr ? ($urandom_range(0, 2) != 0) : 1'b1);
         n++;
      end
      if (done_cnt == 0) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no done required done within %0d cycles", nm, budget);
      end
      repeat (4) tick(1'b0, 1'b1);
      chk({nm, "_outputs"},     32'(out_cnt),     32'(exp_outs));
      chk({nm, "_done_count"},  32'(done_cnt),    32'd1);
      chk({nm, "_out_at_done"}, 32'(out_at_done), 32'(exp_outs));
      chk({nm, "_sb_left"},     32'(sb.size()),   32'd0);
      chk({nm, "_busy_after"},  32'(busy),        32'd0);
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_in_ready"},    32'(in_ready),          32'd0);
      chk({nm, "_shift"},       32'(shifting_line),     32'd0);
      chk({nm, "_lbr"},         32'(line_buffer_reset), 32'd0);
      chk({nm, "_input_line"},  32'(input_line),        32'd0);
      chk({nm, "_pool_enable"}, 32'(pool_enable),       32'd0);
      chk({nm, "_out_valid"},   32'(out_valid),         32'd0);
      chk({nm, "_out_data"},    32'(out_data),          32'd0);
      chk({nm, "_busy"},        32'(busy),              32'd0);
      chk({nm, "_done"},        32'(done),              32'd0);
   endtask

   initial begin
      int n;
      tbl[0] = '{rl: 4, nr: 4, rv: 1'b0, rr: 1'b0, exp_outs: 4};
      tbl[1] = '{rl: 5, nr: 3, rv: 1'b0, rr: 1'b0, exp_outs: 2};
      tbl[2] = '{rl: 4, nr: 4, rv: 1'b1, rr: 1'b1, exp_outs: 4};
      tbl[3] = '{rl: 6, nr: 4, rv: 1'b1, rr: 1'b1, exp_outs: 6};
      tbl[4] = '{rl: 1, nr: 4, rv: 1'b0, rr: 1'b0, exp_outs: 0};
      tbl[5] = '{rl: 3, nr: 5, rv: 1'b1, rr: 1'b0, exp_outs: 2};
      tbl[6] = '{rl: 2, nr: 2, rv: 1'b0, rr: 1'b1, exp_outs: 1};

      rst = 1'b1; start = 1'b0; row_length = '0; num_rows = '0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0; g_start = 1'b0;
      acc_cnt = 0; shift_cnt = 0; rl_cur = 0; total_cur = 0;
      out_cnt = 0; done_cnt = 0; out_at_done = -1; ir_seen = 0; stalls = 0;
      repeat (3) @(negedge clk);
      #1;
      chk_all_zero("reset");
      rst = 1'b0;

      for (int i = 0; i < 7; i++) begin
         begin_frame(tbl[i].rl, tbl[i].nr);
         tick(1'b0, 1'b1);
         finish_frame(2000, tbl[i].rv, tbl[i].rr, tbl[i].exp_outs, $sformatf("frame%0d", i));
      end

      // Zero-pixel frame: one clear cycle, done three cycles after start.
      begin_frame(0, 5);
      tick(1'b0, 1'b1);
      tick(1'b1, 1'b1);
      chk("zero_lbr_on",  32'(line_buffer_reset), 32'd1);
      chk("zero_busy",    32'(busy),              32'd1);
      tick(1'b1, 1'b1);
      chk("zero_lbr_off", 32'(line_buffer_reset), 32'd0);
      chk("zero_no_done", 32'(done),              32'd0);
      tick(1'b1, 1'b1);
      chk("zero_done",    32'(done),              32'd1);
      tick(1'b1, 1'b1);
      chk("zero_done_end", 32'(done),             32'd0);
      chk("zero_idle",     32'(busy),             32'd0);
      chk("zero_in_ready", 32'(ir_seen),          32'd0);
      chk("zero_outputs",  32'(out_cnt),          32'd0);

      // Backpressure: consumer stalled, credit must cap accepted pixels.
      begin_frame(8, 8);
      tick(1'b0, 1'b0);
      n = 0;
      while (stalls < 20 && n < 300) begin
         tick(1'b1, 1'b0);
         n++;
      end
      chk("bp_stalls_reached", 32'(stalls),    32'd20);
      chk("bp_accepted",       32'(acc_cnt),   32'd16);
      chk("bp_in_ready_low",   32'(in_ready),  32'd0);
      chk("bp_out_valid",      32'(out_valid), 32'd1);
      chk("bp_held",           32'(sb.size()), 32'd4);
      head_q = sb[0];
      chk("bp_head",           32'(out_data),  32'(head_q));
      tick(1'b0, 1'b0);
      chk("bp_head_stable",    32'(out_data),  32'(head_q));
      tick(1'b0, 1'b1);
      finish_frame(3000, 1'b0, 1'b0, 16, "bp");
`ifdef POOL_SEQ_PERF_EN
      chk("bp_stall_cycles", stall_cycles, 32'd20);
`endif

      // start during STREAM must not disturb the frame in progress.
      begin_frame(4, 4);
      tick(1'b0, 1'b1);
      repeat (6) tick(1'b1, 1'b1);
      row_length = ADDR_W'(2);
      num_rows   = ADDR_W'(2);
      g_start    = 1'b1;
      tick(1'b1, 1'b1);
      chk("ign_busy", 32'(busy), 32'd1);
      finish_frame(2000, 1'b0, 1'b0, 4, "ign");

      // Reset mid-frame aborts immediately with no done pulse.
      begin_frame(8, 8);
      tick(1'b0, 1'b1);
      repeat (25) tick(1'b1, 1'b0);
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; start = 1'b0;
      @(negedge clk);
      #1;
      chk_all_zero("midrst");
      rst = 1'b0;
      total_cur = 0; out_cnt = 0; done_cnt = 0; sb.delete();
      repeat (10) tick(1'b1, 1'b1);
      chk("midrst_no_done", 32'(done_cnt), 32'd0);
      chk("midrst_no_out",  32'(out_cnt),  32'd0);
      begin_frame(4, 4);
      tick(1'b0, 1'b1);
      finish_frame(2000, 1'b0, 1'b0, 4, "post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
